// File: rtl/uart_rx_ext.sv
// Parametrised UART receiver: 3-sample majority vote, false-start rejection, per-frame perr/ferr/brk flags.
// Frame visible on m_valid one clk after the last stop-bit resolve; a full FIFO with no pop drops the frame and sets overrun.
module uart_rx_ext #(
    parameter int CLK_HZ     = 8000000,
    parameter int BAUD       = 250000,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [DATA_BITS-1:0] m_data,
    output logic                 m_perr,
    output logic                 m_ferr,
    output logic                 m_brk,
    output logic                 overrun,
    input  logic                 ovr_clr
);
    localparam int DIV   = CLK_HZ / (BAUD * OVERSAMPLE);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OS_W  = $clog2(OVERSAMPLE);
    localparam int BC_W  = $clog2(DATA_BITS);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int MID   = OVERSAMPLE / 2;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [OS_W-1:0]  OS_LAST   = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0]  OS_SMP_A  = OS_W'(MID - 1);
    localparam logic [OS_W-1:0]  OS_SMP_B  = OS_W'(MID);
    localparam logic [OS_W-1:0]  OS_RES    = OS_W'(MID + 1);
    localparam logic [BC_W-1:0]  BIT_LAST  = BC_W'(DATA_BITS - 1);
    localparam logic             STOP_LAST = (STOP_BITS == 2);
    localparam logic             PAR_ODD   = (PARITY == 1);
    localparam logic [AW:0]      CNT_FULL  = (AW + 1)'(FIFO_DEPTH);

    if (DIV < 1 || (CLK_HZ % (BAUD * OVERSAMPLE)) != 0) begin : g_bad_div
        $error("uart_rx_ext: CLK_HZ/(BAUD*OVERSAMPLE) must be an integer >= 1");
    end
    if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_bad_os
        $error("uart_rx_ext: OVERSAMPLE must be even and >= 8");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_fmt
        $error("uart_rx_ext: unsupported frame format");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_rx_ext: FIFO_DEPTH must be a power of 2 and >= 2");
    end

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

    typedef struct packed {
        logic                 brk;
        logic                 ferr;
        logic                 perr;
        logic [DATA_BITS-1:0] data;
    } frame_t;

    state_t               r_state;
    state_t               w_next;
    logic                 r_sync1, r_rxs, r_rxs_d;
    logic [DIV_W-1:0]     r_div_cnt;
    logic [OS_W-1:0]      r_os_cnt;
    logic                 r_smp0, r_smp1;
    logic [BC_W-1:0]      r_bit_cnt;
    logic                 r_stop_cnt;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_pbit, r_perr, r_ferr, r_stop0;
    frame_t               r_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_wptr, r_rptr;
    logic [AW:0]          r_cnt;
    logic                 r_ovr;

    logic   w_fall, w_tick, w_res, w_bit, w_start, w_push, w_pop, w_full, w_wr, w_ovr_set;
    frame_t w_frame, w_head;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_rxs   <= 1'b1;
            r_rxs_d <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_rxs   <= r_sync1;
            r_rxs_d <= r_rxs;
        end
    end

    assign w_fall = r_rxs_d & ~r_rxs;
    assign w_tick = (r_div_cnt == DIV_LAST);
    assign w_res  = w_tick && (r_os_cnt == OS_RES);
    assign w_bit  = (r_smp0 & r_smp1) | (r_smp0 & r_rxs) | (r_smp1 & r_rxs);

    // The detected edge counts as tick 0, so tick MID lands on the bit centre.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div_cnt <= '0;
            r_os_cnt  <= '0;
        end else if (w_start) begin
            r_div_cnt <= '0;
            r_os_cnt  <= OS_W'(1);
        end else if (w_tick) begin
            r_div_cnt <= '0;
            r_os_cnt  <= (r_os_cnt == OS_LAST) ? '0 : r_os_cnt + OS_W'(1);
        end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_smp0 <= 1'b1;
            r_smp1 <= 1'b1;
        end else begin
            if (w_tick && r_os_cnt == OS_SMP_A) r_smp0 <= r_rxs;
            if (w_tick && r_os_cnt == OS_SMP_B) r_smp1 <= r_rxs;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_fall) w_next = S_START;
            S_START: if (w_res) w_next = w_bit ? S_IDLE : S_DATA;
            S_DATA:  if (w_res && r_bit_cnt == BIT_LAST) w_next = (PARITY != 0) ? S_PAR : S_STOP;
            S_PAR:   if (w_res) w_next = S_STOP;
            S_STOP:  if (w_res && r_stop_cnt == STOP_LAST) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_start      = (r_state == S_IDLE) && w_fall;
        w_push       = (r_state == S_STOP) && w_res && (r_stop_cnt == STOP_LAST);
        w_frame      = '0;
        w_frame.data = r_data;
        w_frame.perr = r_perr;
        w_frame.ferr = r_ferr | ~w_bit;
        w_frame.brk  = (r_data == '0) && !r_pbit && r_stop0 && !w_bit;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_data     <= '0;
            r_pbit     <= 1'b0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
            r_stop0    <= 1'b1;
        end else if (w_start) begin
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_pbit     <= 1'b0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
            r_stop0    <= 1'b1;
        end else if (w_res) begin
            case (r_state)
                S_DATA: begin
                    r_data[r_bit_cnt] <= w_bit;
                    r_bit_cnt         <= r_bit_cnt + BC_W'(1);
                end
                S_PAR: begin
                    r_pbit <= w_bit;
                    r_perr <= ((^r_data) ^ w_bit) != PAR_ODD;
                end
                S_STOP: begin
                    r_stop_cnt <= 1'b1;
                    r_ferr     <= r_ferr | ~w_bit;
                    r_stop0    <= r_stop0 & ~w_bit;
                end
                default: ;
            endcase
        end
    end

    assign w_pop     = m_valid && m_ready;
    assign w_full    = (r_cnt == CNT_FULL);
    assign w_wr      = w_push && (!w_full || w_pop);
    assign w_ovr_set = w_push && w_full && !w_pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
        end else if (w_wr) begin
            r_mem[r_wptr] <= w_frame;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
            r_ovr  <= 1'b0;
        end else begin
            if (w_wr)  r_wptr <= r_wptr + AW'(1);
            if (w_pop) r_rptr <= r_rptr + AW'(1);
            case ({w_wr, w_pop})
                2'b10:   r_cnt <= r_cnt + (AW + 1)'(1);
                2'b01:   r_cnt <= r_cnt - (AW + 1)'(1);
                default: r_cnt <= r_cnt;
            endcase
            if (w_ovr_set)    r_ovr <= 1'b1;
            else if (ovr_clr) r_ovr <= 1'b0;
        end
    end

    assign w_head  = r_mem[r_rptr];
    assign m_valid = (r_cnt != '0);
    assign m_data  = w_head.data;
    assign m_perr  = w_head.perr;
    assign m_ferr  = w_head.ferr;
    assign m_brk   = w_head.brk;
    assign overrun = r_ovr;
endmodule

// File: tb/tb_uart_rx_ext.sv
`timescale 1ns/1ps
module tb_uart_rx_ext;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, rx0, rx1, rdy0, rdy1, clr0, clr1;
    logic       v0, v1, pe0, fe0, bk0, ov0, pe1, fe1, bk1, ov1;
    logic [7:0] d0, d1;

    // u0: default 8N1, 32 clk/bit. u1: even parity, two stop bits.
    uart_rx_ext u0 (
        .clk(clk), .rst(rst), .rx(rx0), .m_valid(v0), .m_ready(rdy0), .m_data(d0),
        .m_perr(pe0), .m_ferr(fe0), .m_brk(bk0), .overrun(ov0), .ovr_clr(clr0)
    );
    uart_rx_ext #(.PARITY(2), .STOP_BITS(2)) u1 (
        .clk(clk), .rst(rst), .rx(rx1), .m_valid(v1), .m_ready(rdy1), .m_data(d1),
        .m_perr(pe1), .m_ferr(fe1), .m_brk(bk1), .overrun(ov1), .ovr_clr(clr1)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    logic [10:0] q0[$], q1[$];
    int          t0[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Beats are {brk, ferr, perr, data}; a handshake completes on the next rising edge.
    always @(negedge clk) begin
        if (!rst && v0 && rdy0) begin
            q0.push_back({bk0, fe0, pe0, d0});
            t0.push_back(cyc);
        end
        if (!rst && v1 && rdy1) q1.push_back({bk1, fe1, pe1, d1});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_beat(input int ch, input string tag, input logic [10:0] exp);
        logic [10:0] got;
        got = 11'h7ff;
        if (ch == 0 && q0.size() > 0) got = q0.pop_front();
        if (ch == 1 && q1.size() > 0) got = q1.pop_front();
        check(tag, 32'(got), 32'(exp));
    endtask

    task automatic hold(input int ch, input logic v, input int n);
        if (ch == 0) rx0 = v;
        else         rx1 = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input int ch, input logic [15:0] bits, input int nb);
        for (int i = 0; i < nb; i++) hold(ch, bits[i], 32);
    endtask

    int dt;
    int tstop;

    initial begin
        rst = 1'b1; rx0 = 1'b1; rx1 = 1'b1;
        rdy0 = 1'b1; rdy1 = 1'b1; clr0 = 1'b0; clr1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid0", 32'(v0), 0);
        check("rst_head0", 32'({bk0, fe0, pe0, d0}), 0);
        check("rst_ovr0", 32'(ov0), 0);
        check("rst_valid1", 32'(v1), 0);
        check("rst_head1", 32'({bk1, fe1, pe1, d1}), 0);
        rst = 1'b0;
        hold(0, 1'b1, 64);

        // 8N1 0xAB with latency measured from the start of the stop bit
        send(0, {7'b0, 8'hAB, 1'b0}, 9);
        tstop = cyc;
        hold(0, 1'b1, 64);
        check("8n1_count", 32'(q0.size()), 1);
        dt = (t0.size() > 0) ? t0.pop_front() - tstop : -1;
        check("8n1_latency", 32'(dt >= 19 && dt <= 21), 1);
        chk_beat(0, "8n1_beat", {3'b000, 8'hAB});

        // even parity: 0x5A has four ones, so the correct parity bit is 0
        send(1, {4'b0, 1'b1, 1'b1, 1'b0, 8'h5A, 1'b0}, 12);
        hold(1, 1'b1, 64);
        send(1, {4'b0, 1'b1, 1'b1, 1'b1, 8'h5A, 1'b0}, 12);
        hold(1, 1'b1, 64);
        check("par_count", 32'(q1.size()), 2);
        chk_beat(1, "par_ok", {3'b000, 8'h5A});
        chk_beat(1, "par_bad", {3'b001, 8'h5A});

        // second stop bit low
        send(1, {4'b0, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b0}, 12);
        hold(1, 1'b1, 64);
        check("stop2_count", 32'(q1.size()), 1);
        chk_beat(1, "stop2_ferr", {3'b010, 8'h3C});

        // 12-clk glitch is a false start; receiver must still take the next frame
        hold(1, 1'b0, 12);
        hold(1, 1'b1, 96);
        check("glitch_none", 32'(q1.size()), 0);
        send(1, {4'b0, 1'b1, 1'b1, 1'b0, 8'h11, 1'b0}, 12);
        hold(1, 1'b1, 64);
        check("after_glitch_count", 32'(q1.size()), 1);
        chk_beat(1, "after_glitch_beat", {3'b000, 8'h11});

        // 0x00 with a 4-clk high spike in data bit 3 covering one of the three samples
        hold(0, 1'b0, 32 * 4);
        hold(0, 1'b0, 11);
        hold(0, 1'b1, 4);
        hold(0, 1'b0, 17);
        hold(0, 1'b0, 32 * 4);
        hold(0, 1'b1, 64);
        check("spike_count", 32'(q0.size()), 1);
        chk_beat(0, "spike_beat", {3'b000, 8'h00});

        // overrun: five frames into a depth-4 FIFO with the consumer stalled
        rdy0 = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            send(0, {6'b0, 1'b1, 8'(i), 1'b0}, 10);
            hold(0, 1'b1, 32);
        end
        check("ovr_set", 32'(ov0), 1);
        check("ovr_valid", 32'(v0), 1);
        check("ovr_head", 32'(d0), 1);
        rdy0 = 1'b1;
        hold(0, 1'b1, 8);
        check("drain_count", 32'(q0.size()), 4);
        for (int i = 1; i <= 4; i++) chk_beat(0, $sformatf("drain_%0d", i), {3'b000, 8'(i)});
        check("drain_empty", 32'(v0), 0);
        check("ovr_sticky", 32'(ov0), 1);
        clr0 = 1'b1;
        hold(0, 1'b1, 1);
        clr0 = 1'b0;
        check("ovr_clr", 32'(ov0), 0);

        // line held low for 20 bit times: exactly one break frame
        hold(0, 1'b0, 640);
        hold(0, 1'b1, 96);
        check("brk_count", 32'(q0.size()), 1);
        chk_beat(0, "brk_beat", {3'b110, 8'h00});
        hold(0, 1'b1, 96);
        check("brk_no_more", 32'(q0.size()), 0);

        // reset mid-frame with a frame already buffered
        rdy0 = 1'b0;
        send(0, {6'b0, 1'b1, 8'h77, 1'b0}, 10);
        hold(0, 1'b1, 32);
        check("pre_rst_valid", 32'(v0), 1);
        hold(0, 1'b0, 32);
        hold(0, 1'b1, 16);
        rst = 1'b1;
        hold(0, 1'b1, 4);
        check("rst_mid_valid", 32'(v0), 0);
        check("rst_mid_data", 32'(d0), 0);
        rst = 1'b0;
        hold(0, 1'b1, 32 * 12);
        check("post_rst_valid", 32'(v0), 0);
        check("post_rst_ovr", 32'(ov0), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_rx_ext.md
Name: uart_rx_ext

Overview:
Parametrised UART receiver, successor to the fixed 8N1 receiver. Supports configurable data width, parity, stop bits and oversampling, with majority-vote sampling and false-start rejection. Frames are reported with per-frame error flags. Received frames are buffered in a first-word-fall-through FIFO and presented on a valid/ready stream toward the consuming logic.

Parameters:
CLK_HZ, 8000000, system clock frequency in Hz.
BAUD, 250000, line bit rate; CLK_HZ/(BAUD*OVERSAMPLE) must be an integer >=1 (elaboration $error otherwise).
OVERSAMPLE, 16, ticks per bit; even, >=8.
DATA_BITS, 8, payload bits per frame, 5..9.
PARITY, 0, 0=none, 1=odd, 2=even.
STOP_BITS, 1, 1 or 2.
FIFO_DEPTH, 4, frame buffer entries; power of 2, >=2.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
rx  in  1  serial line, idle high, asynchronous to clk
m_valid  out  1  FIFO head holds a frame
m_ready  in  1  consumer accepts head frame
m_data  out  DATA_BITS  received payload, LSB = first bit on line
m_perr  out  1  parity error for head frame (0 when PARITY=0)
m_ferr  out  1  framing error for head frame (any stop bit sampled 0)
m_brk  out  1  break: payload, parity and stop all sampled 0
overrun  out  1  sticky: a frame was dropped because the FIFO was full
ovr_clr  in  1  synchronous clear of overrun

Behaviour:
- Reset (async assert, sync release): sync flops=1, FSM=IDLE, tick counter=0, FIFO empty, m_valid=0, m_data/m_perr/m_ferr/m_brk=0, overrun=0.
- rx passes through a 2-flop synchroniser reset to 1; all logic uses the synchronised value rxs.
- Tick generator: divides clk by DIV=CLK_HZ/(BAUD*OVERSAMPLE). Free-running in IDLE. Restarted at 0 on start-edge detection so sample phase aligns to the edge.
- Bit sampling: within each bit, take rxs on ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1. Bit value = majority of 3. The bit is resolved on tick OVERSAMPLE/2+1.
- FSM:
  - IDLE: rxs 1->0 transition -> START.
  - START: resolve start bit. If 1 -> IDLE (false start, nothing pushed). If 0 -> DATA.
  - DATA: DATA_BITS bits, LSB first, bit counter 0..DATA_BITS-1. After the last bit -> PARITY if PARITY!=0, else STOP.
  - PARITY: perr = (XOR of data ^ parity bit) != (PARITY==1 ? 1 : 0). Odd parity requires total ones count odd. Then -> STOP.
  - STOP: resolve STOP_BITS stop bits; ferr=1 if any resolves 0. On the last stop resolve: push frame and -> IDLE in the same cycle, so a start edge is detectable during the remainder of the stop bit.
- Break flag: brk=1 when data==0, the parity bit (if present) is 0, and all stop bits are 0. ferr is also 1 in this case.
- Erroneous frames are pushed with their flags; they are not dropped.
- FIFO behaviour:
  - Push occurs on the last-stop-resolve cycle; m_valid rises on the next clk edge if the FIFO was empty.
  - Pop when m_valid && m_ready. Outputs reflect the head entry combinationally from FIFO storage.
  - Full with no pop at push: frame discarded, overrun<=1.
  - Full with simultaneous pop: push accepted, no overrun.
  - Empty: m_ready ignored; m_data/flags hold the last head value (do not care to consumers).
  - Pointers wrap modulo FIFO_DEPTH; use count width log2(FIFO_DEPTH)+1.
- overrun: set has priority over ovr_clr in the same cycle.
- Reset mid-frame: FSM returns to IDLE and FIFO contents are lost. After release, rxs must be seen 1 before a falling edge can start a frame, because the synchroniser is reset to 1.
- Line held low at idle: exactly one frame is pushed, with brk=1. No new frame starts until rxs returns to 1 and falls again.

Test Plan:
- Defaults (32 clk/bit), m_ready=1, send 0xAB in 8N1 -> one beat m_data=0xAB, perr=0, ferr=0, brk=0. m_valid rises within 2 clk after the stop-bit centre plus 2 sync cycles.
- PARITY=2, send 0x5A with correct parity then with inverted parity bit -> beats {0x5A, perr=0} then {0x5A, perr=1}.
- STOP_BITS=2, second stop bit driven 0 for 0x3C -> m_data=0x3C, ferr=1. A 12-clk (<half-bit) low glitch on idle line -> no frame, FSM back to IDLE.
- Single 4-clk inverted spike at mid-bit on data bit 3 of 0x00 -> majority vote yields m_data=0x00.
- m_ready=0, send 5 frames 0x01..0x05 with FIFO_DEPTH=4 -> overrun=1, FIFO holds 0x01..0x04. Raise m_ready: 4 beats in order. Pulse ovr_clr -> overrun=0.
- rx held 0 for 20 bit times -> one frame with data=0, ferr=1, brk=1 and no further frames. Assert rst mid-frame -> m_valid=0 and no frame is pushed after release.
